// File: rtl/dec_pkg.sv
// Shared definitions for the decimal arithmetic blocks: digit width,
// largest legal BCD digit and the subtractor control states.
package dec_pkg;

   localparam int BCD_W = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/dec_sub_digit.sv
// Combinational single-digit BCD subtract stage: d = a - b - b_in, folded
// back into 0..9 with a borrow when the raw difference goes negative.
module dec_sub_digit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       b_in,
   output logic [3:0] d,
   output logic       b_out
);

   logic [4:0] diff;

   // Bit 4 of the 5-bit two's-complement difference is the sign.
   always_comb begin
      diff  = {1'b0, a} - {1'b0, b} - {4'b0000, b_in};
      b_out = diff[4];
      d     = diff[4] ? (diff[3:0] + 4'd10) : diff[3:0];
   end

endmodule

// File: rtl/dec_subtractor.sv
// Digit-serial BCD subtractor computing A - B one digit per clock, least
// significant digit first, with a start/busy/done handshake.
module dec_subtractor
   import dec_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   A,
   input  logic [4*DIGITS-1:0]   B,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   s,
   output logic                  b_out,
   output logic                  err
);

   localparam int W     = BCD_W * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

   state_t           state, stateNext;
   logic [W-1:0]     areg, breg, res, resNext;
   logic [IDX_W-1:0] idx;
   logic             borrow, errLatch, badIn;
   logic [3:0]       aDig, bDig, dig;
   logic             digBorrow;

   dec_sub_digit u_digit (
      .a     (aDig),
      .b     (bDig),
      .b_in  (borrow),
      .d     (dig),
      .b_out (digBorrow)
   );

   always_comb begin
      aDig    = areg[idx*BCD_W +: BCD_W];
      bDig    = breg[idx*BCD_W +: BCD_W];
      resNext = res;
      resNext[idx*BCD_W +: BCD_W] = dig;
   end

   // Operand validity is judged on the values being latched this edge.
   always_comb begin
      badIn = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (A[i*BCD_W +: BCD_W] > BCD_MAX || B[i*BCD_W +: BCD_W] > BCD_MAX)
            badIn = 1'b1;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE: if (start) stateNext = ST_CALC;
         ST_CALC: if (idx == LAST) stateNext = ST_DONE;
         ST_DONE: stateNext = start ? ST_CALC : ST_IDLE;
         default: stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= stateNext;
   end

   // Published results only change on the final digit, so they hold
   // through IDLE and while the next operation is running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         areg     <= '0;
         breg     <= '0;
         res      <= '0;
         idx      <= '0;
         borrow   <= 1'b0;
         errLatch <= 1'b0;
         s        <= '0;
         b_out    <= 1'b0;
         err      <= 1'b0;
      end else if (state != ST_CALC && start) begin
         areg     <= A;
         breg     <= B;
         idx      <= '0;
         borrow   <= 1'b0;
         errLatch <= badIn;
      end else if (state == ST_CALC) begin
         res    <= resNext;
         borrow <= digBorrow;
         if (idx == LAST) begin
            idx   <= '0;
            s     <= errLatch ? '0 : resNext;
            b_out <= errLatch ? 1'b0 : digBorrow;
            err   <= errLatch;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign busy = (state == ST_CALC);
   assign done = (state == ST_DONE);

endmodule

// File: doc/dec_subtractor.md
Name: dec_subtractor

Overview:
Digit-serial multi-digit BCD subtractor that computes A - B, the inverse of the team's parallel decimal adder. It processes one BCD digit per clock, least-significant digit first, and carries a borrow between digits. A start/busy/done handshake lets a controller or testbench issue operations back to back. It sits beside the decimal adder in the arithmetic datapath and produces a ten's-complement difference plus a borrow-out.

Parameters:
DIGITS, 2, number of BCD digits per operand (must be >= 1)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE or DONE
A  input  4*DIGITS  minuend, packed BCD; digit i = A[4i+3:4i], digit 0 least significant
B  input  4*DIGITS  subtrahend, packed BCD, same packing as A
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when results are valid
s  output  4*DIGITS  difference, packed BCD (ten's complement when b_out=1)
b_out  output  1  final borrow; 1 means A < B
err  output  1  an operand digit was > 9 for this operation

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, s=0, b_out=0, err=0; digit index and internal borrow cleared. Any operation in flight is abandoned, with no done pulse.
- States:
  - IDLE.
  - CALC: busy=1.
  - DONE: done=1 for exactly one cycle.
- IDLE or DONE, start=1 at an edge:
  - Latch A and B into internal registers; later input changes are ignored.
  - idx=0, borrow=0.
  - err_next = 1 if any latched digit of A or B > 9.
  - Go to CALC.
  - s, b_out and err keep their previous values until the new result is written.
- IDLE, start=0: stay in IDLE.
- DONE, start=0: go to IDLE. done drops after one cycle in every case.
- CALC, each edge, for digit idx:
  - d = a_idx - b_idx - borrow, in 5-bit signed arithmetic.
  - If d < 0: digit = d + 10 and borrow = 1. Otherwise digit = d and borrow = 0.
  - Write the digit into the result shift register at slot idx; idx++.
  - When idx == DIGITS-1: go to DONE and register s, b_out=borrow, err=err_next.
- Latency: the start edge is edge 0; done is high in the cycle after edge DIGITS. Default parameters give done two cycles after start is sampled.
- start during CALC is ignored. No queueing, and the latched operands are not disturbed.
- Result when A < B: s = 10^DIGITS + A - B and b_out = 1. Example: 24-26 gives s=98, b_out=1.
- Invalid operand (err=1): latency is unchanged; s is forced to 0 and b_out to 0.
- Outputs s, b_out and err hold their last value through IDLE until the next DONE.
- idx is wide enough for DIGITS-1: $clog2(DIGITS), minimum 1 bit.

Decomposition:
- Shared package or include file dec_pkg:
  - BCD_W=4.
  - State encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - Constant BCD_MAX=9.
- One natural sub-module, dec_sub_digit: a combinational single-digit stage.
  - Inputs a[3:0], b[3:0], b_in.
  - Outputs d[3:0], b_out.
  - Instantiated once; the top level muxes the operand digit selected by idx into it.
- The top level holds the FSM, operand registers, index counter and result assembly.

Test Plan:
- A1=5 A0=3, B1=2 B0=1, start pulse -> done 2 cycles later; s=0x32 (32), b_out=0, err=0, busy high for 2 cycles.
- A=0x24, B=0x26 -> s=0x98, b_out=1. A=0x00, B=0x01 -> s=0x99, b_out=1. A=0x90, B=0x09 -> s=0x81, b_out=0 (borrow ripples across digit 0).
- Start A=0x50, B=0x25; change A and B and pulse start again while busy=1 -> single done pulse, s=0x25; the second start is ignored.
- Assert rst for one cycle midway through CALC -> busy, done, s, b_out and err go to 0 immediately; no done pulse afterwards; a new start then completes normally.
- A=0x4A, B=0x11 -> err=1, s=0x00, b_out=0, done after 2 cycles. The next valid op A=0x11, B=0x11 -> s=0x00, err=0.
- Back-to-back: start held high continuously -> done pulses every 3 cycles (IDLE/DONE, CALC, CALC), with each result matching the operands latched at its start edge.
